// File: rtl/ram_addr_seq_pkg.sv
// Shared types and helpers for the RAM read-address sequencer.
// Holds the FSM state type, phase-width helper and start-config validity check.
package ram_addr_seq_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam int unsigned DefAwidth = 10;
    localparam int unsigned DefFwidth = 16;

    // One extra integer bit so phase + step never overflows before the wrap compare.
    function automatic int unsigned phase_width(input int unsigned awidth,
                                                input int unsigned fwidth);
        return awidth + 1 + fwidth;
    endfunction

    localparam int unsigned DefPhaseW = phase_width(DefAwidth, DefFwidth);

    function automatic logic cfg_valid(input logic [31:0] table_len,
                                       input logic [31:0] max_len,
                                       input logic [31:0] frame_len,
                                       input logic [31:0] step_int);
        return (table_len != 32'd0) && (table_len <= max_len) &&
               (frame_len != 32'd0) && (step_int < table_len);
    endfunction

endpackage

// File: rtl/phase_wrap_acc.sv
// Fractional phase accumulator that wraps modulo the table length.
// The phase register is the currently presented beat; int/frac are read straight from it.
module phase_wrap_acc
    import ram_addr_seq_pkg::*;
#(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned FWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_i,
    input  logic                     advance_i,
    input  logic [AWIDTH+FWIDTH-1:0] step_i,
    input  logic [AWIDTH:0]          len_i,
    output logic [AWIDTH-1:0]        int_o,
    output logic [FWIDTH-1:0]        frac_o
);

    localparam int unsigned PW = phase_width(AWIDTH, FWIDTH);

    logic [PW-1:0] phase_q, phase_d, sum, len_fix;

    assign sum     = phase_q + PW'(step_i);
    assign len_fix = {len_i, {FWIDTH{1'b0}}};

    // step < len guarantees one subtract brings the sum back into range.
    always_comb begin
        phase_d = phase_q;
        if (load_i) begin
            phase_d = '0;
        end else if (advance_i) begin
            phase_d = (sum[PW-1:FWIDTH] >= len_i) ? (sum - len_fix) : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign int_o  = phase_q[FWIDTH +: AWIDTH];
    assign frac_o = phase_q[FWIDTH-1:0];

endmodule

// File: rtl/ram_addr_sequencer.sv
// Framed AXI-stream read-address generator for a coefficient RAM with
// fractional phase on tuser for downstream interpolation.
module ram_addr_sequencer
    import ram_addr_seq_pkg::*;
#(
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned FWIDTH = 16,
    parameter int unsigned LWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic [AWIDTH:0]          cfg_table_len,
    input  logic [AWIDTH+FWIDTH-1:0] cfg_step,
    input  logic [LWIDTH-1:0]        cfg_frame_len,
    input  logic [LWIDTH-1:0]        cfg_num_frames,
    input  logic                     start,
    input  logic                     stop,
    output logic [AWIDTH-1:0]        o_tdata,
    output logic [FWIDTH-1:0]        o_tuser,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    state_e                    state_q, state_d;
    logic [LWIDTH-1:0]         beat_q, beat_d, frame_q, frame_d;
    logic [LWIDTH-1:0]         flen_q, flen_d, nframes_q, nframes_d;
    logic [AWIDTH:0]           len_q, len_d;
    logic [AWIDTH+FWIDTH-1:0]  step_q, step_d;
    logic                      stop_pending_q, stop_pending_d;
    logic                      tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic                      done_q, done_d, cfg_err_q, cfg_err_d;
    logic                      load, advance, accept, last_frame, start_ok;

    assign start_ok = cfg_valid(32'(cfg_table_len), 32'(1) << AWIDTH, 32'(cfg_frame_len),
                                32'(cfg_step[AWIDTH+FWIDTH-1:FWIDTH]));
    assign accept     = tvalid_q & o_tready;
    assign last_frame = (nframes_q != '0) && (frame_q == nframes_q - LWIDTH'(1));

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        frame_d        = frame_q;
        flen_d         = flen_q;
        nframes_d      = nframes_q;
        len_d          = len_q;
        step_d         = step_q;
        stop_pending_d = stop_pending_q;
        tvalid_d       = tvalid_q;
        tlast_d        = tlast_q;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        load           = 1'b0;
        advance        = 1'b0;
        if (clear) begin
            state_d        = StIdle;
            tvalid_d       = 1'b0;
            tlast_d        = 1'b0;
            stop_pending_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && start_ok) begin
                        state_d        = StRun;
                        len_d          = cfg_table_len;
                        step_d         = cfg_step;
                        flen_d         = cfg_frame_len;
                        nframes_d      = cfg_num_frames;
                        beat_d         = '0;
                        frame_d        = '0;
                        stop_pending_d = stop;
                        tvalid_d       = 1'b1;
                        tlast_d        = (cfg_frame_len == LWIDTH'(1));
                        load           = 1'b1;
                    end else if (start) begin
                        cfg_err_d = 1'b1;
                    end
                end
                StRun: begin
                    if (stop) stop_pending_d = 1'b1;
                    if (accept) begin
                        advance = 1'b1;
                        if (tlast_q && (last_frame || stop_pending_q)) begin
                            state_d        = StIdle;
                            tvalid_d       = 1'b0;
                            tlast_d        = 1'b0;
                            done_d         = 1'b1;
                            stop_pending_d = 1'b0;
                        end else if (tlast_q) begin
                            frame_d = frame_q + LWIDTH'(1);
                            beat_d  = '0;
                            tlast_d = (flen_q == LWIDTH'(1));
                        end else begin
                            beat_d  = beat_q + LWIDTH'(1);
                            tlast_d = ((beat_q + LWIDTH'(1)) == (flen_q - LWIDTH'(1)));
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            frame_q        <= '0;
            flen_q         <= '0;
            nframes_q      <= '0;
            len_q          <= '0;
            step_q         <= '0;
            stop_pending_q <= 1'b0;
            tvalid_q       <= 1'b0;
            tlast_q        <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            frame_q        <= frame_d;
            flen_q         <= flen_d;
            nframes_q      <= nframes_d;
            len_q          <= len_d;
            step_q         <= step_d;
            stop_pending_q <= stop_pending_d;
            tvalid_q       <= tvalid_d;
            tlast_q        <= tlast_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    phase_wrap_acc #(
        .AWIDTH(AWIDTH),
        .FWIDTH(FWIDTH)
    ) u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (load),
        .advance_i(advance),
        .step_i   (step_q),
        .len_i    (len_q),
        .int_o    (o_tdata),
        .frac_o   (o_tuser)
    );

    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_ram_addr_sequencer.sv
// Directed self-checking bench for ram_addr_sequencer.
module tb_ram_addr_sequencer;

    localparam int AW = 10;
    localparam int FW = 16;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset_n, clear, start, stop, o_tready;
    logic [AW:0]     cfg_table_len;
    logic [AW+FW-1:0] cfg_step;
    logic [LW-1:0]   cfg_frame_len, cfg_num_frames;
    logic [AW-1:0]   o_tdata;
    logic [FW-1:0]   o_tuser;
    logic            o_tlast, o_tvalid, busy, done, cfg_err;

    int n_checks = 0;
    int n_pass   = 0;
    int got_addr[$];
    int got_user[$];
    int got_last[$];
    int n_done, done_at, last_at;

    always #5 clk = ~clk;

    ram_addr_sequencer #(.AWIDTH(AW), .FWIDTH(FW), .LWIDTH(LW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .cfg_table_len (cfg_table_len),
        .cfg_step      (cfg_step),
        .cfg_frame_len (cfg_frame_len),
        .cfg_num_frames(cfg_num_frames),
        .start         (start),
        .stop          (stop),
        .o_tdata       (o_tdata),
        .o_tuser       (o_tuser),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    // Returns at the negedge after the posedge that sampled start.
    task automatic start_run(input int len, input int step, input int flen, input int nf,
                             input bit with_stop);
        @(negedge clk);
        cfg_table_len  = len[AW:0];
        cfg_step       = step[AW+FW-1:0];
        cfg_frame_len  = flen[LW-1:0];
        cfg_num_frames = nf[LW-1:0];
        start          = 1'b1;
        stop           = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic collect(input int budget, input bit rnd, input int stop_at);
        logic [AW-1:0] pd;
        logic [FW-1:0] pu;
        logic          pl;
        bit            stall;
        stall = 1'b0;
        pd = '0; pu = '0; pl = 1'b0;
        got_addr.delete(); got_user.delete(); got_last.delete();
        n_done = 0; done_at = -1; last_at = -1;
        for (int c = 0; c < budget; c++) begin
            if (stall) begin
                n_checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== pd || o_tuser !== pu || o_tlast !== pl)
                    $display("FAIL stall_hold c=%0d got v=%b a=%0d u=%h l=%b need v=1 a=%0d u=%h l=%b",
                             c, o_tvalid, o_tdata, o_tuser, o_tlast, pd, pu, pl);
                else n_pass++;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            stop     = (c == stop_at);
            o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_tvalid === 1'b1 && o_tready) begin
                got_addr.push_back(int'(o_tdata));
                got_user.push_back(int'(o_tuser));
                got_last.push_back(int'(o_tlast));
                last_at = c;
            end
            stall = (o_tvalid === 1'b1) && !o_tready;
            pd = o_tdata; pu = o_tuser; pl = o_tlast;
            @(negedge clk);
        end
        stop     = 1'b0;
        o_tready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n_checks++;
        if (o_tvalid !== 1'b0 || o_tlast !== 1'b0) $display("FAIL reset_valid_last got %b%b need 00", o_tvalid, o_tlast);
        else n_pass++;
        n_checks++;
        if (o_tdata !== '0 || o_tuser !== '0) $display("FAIL reset_data got %0d/%h need 0/0", o_tdata, o_tuser);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL reset_status got busy=%b done=%b err=%b need 000", busy, done, cfg_err);
        else n_pass++;
    endtask

    task automatic check_linear8(input string name, input bit rnd);
        n_checks++;
        if (got_addr.size() != 8) $display("FAIL %s_count got %0d need 8", name, got_addr.size());
        else n_pass++;
        for (int i = 0; i < got_addr.size() && i < 8; i++) begin
            n_checks++;
            if (got_addr[i] != i || got_user[i] != 0 || got_last[i] != int'(i == 3 || i == 7))
                $display("FAIL %s_beat%0d got a=%0d u=%h l=%0d need a=%0d u=0 l=%0d", name, i,
                         got_addr[i], got_user[i], got_last[i], i, int'(i == 3 || i == 7));
            else n_pass++;
        end
        n_checks++;
        if (n_done != 1 || done_at != last_at + 1)
            $display("FAIL %s_done got n=%0d at=%0d need n=1 at=%0d", name, n_done, done_at, last_at + 1);
        else n_pass++;
        if (!rnd) begin
            n_checks++;
            if (last_at != 7) $display("FAIL %s_latency got last_at=%0d need 7", name, last_at);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0 || o_tvalid !== 1'b0) $display("FAIL %s_idle got busy=%b v=%b need 0 0", name, busy, o_tvalid);
        else n_pass++;
    endtask

    task automatic test_linear();
        start_run(8, 'h10000, 4, 2, 1'b0);
        // Config changes after start must not affect the run.
        cfg_table_len = 3;
        cfg_step      = 'h30000;
        collect(20, 1'b0, -1);
        check_linear8("linear", 1'b0);
    endtask

    task automatic test_fractional();
        int ea[6] = '{0, 1, 3, 4, 1, 2};
        int eu[6] = '{0, 'h8000, 0, 'h8000, 0, 'h8000};
        start_run(5, 'h18000, 6, 1, 1'b0);
        collect(16, 1'b0, -1);
        n_checks++;
        if (got_addr.size() != 6) $display("FAIL frac_count got %0d need 6", got_addr.size());
        else n_pass++;
        for (int i = 0; i < got_addr.size() && i < 6; i++) begin
            n_checks++;
            if (got_addr[i] != ea[i] || got_user[i] != eu[i] || got_last[i] != int'(i == 5))
                $display("FAIL frac_beat%0d got a=%0d u=%h l=%0d need a=%0d u=%h l=%0d", i,
                         got_addr[i], got_user[i], got_last[i], ea[i], eu[i], int'(i == 5));
            else n_pass++;
        end
        n_checks++;
        if (n_done != 1 || done_at != 6) $display("FAIL frac_done got n=%0d at=%0d need n=1 at=6", n_done, done_at);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        start_run(8, 'h10000, 4, 2, 1'b0);
        collect(80, 1'b1, -1);
        check_linear8("bp", 1'b1);
    endtask

    task automatic test_stop();
        start_run(8, 'h10000, 3, 0, 1'b0);
        collect(30, 1'b0, 7);
        n_checks++;
        if (got_addr.size() != 9) $display("FAIL stop_count got %0d need 9", got_addr.size());
        else n_pass++;
        for (int i = 0; i < got_addr.size() && i < 9; i++) begin
            n_checks++;
            if (got_addr[i] != i % 8 || got_last[i] != int'(i % 3 == 2))
                $display("FAIL stop_beat%0d got a=%0d l=%0d need a=%0d l=%0d", i, got_addr[i],
                         got_last[i], i % 8, int'(i % 3 == 2));
            else n_pass++;
        end
        n_checks++;
        if (n_done != 1 || done_at != 9) $display("FAIL stop_done got n=%0d at=%0d need n=1 at=9", n_done, done_at);
        else n_pass++;
    endtask

    task automatic test_clear();
        bit bad;
        start_run(8, 'h10000, 4, 1, 1'b0);
        o_tready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 10'd2) $display("FAIL clear_pre got v=%b a=%0d need v=1 a=2", o_tvalid, o_tdata);
        else n_pass++;
        o_tready = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL clear_abort got v=%b busy=%b done=%b need 000", o_tvalid, busy, done);
        else n_pass++;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || o_tvalid !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL clear_quiet got activity after clear need none");
        else n_pass++;
        o_tready = 1'b1;
        start_run(8, 'h10000, 4, 1, 1'b0);
        collect(12, 1'b0, -1);
        n_checks++;
        if (got_addr.size() != 4 || got_addr[0] != 0 || got_last[3] != 1 || n_done != 1)
            $display("FAIL clear_restart got n=%0d a0=%0d done=%0d need n=4 a0=0 done=1",
                     got_addr.size(), got_addr.size() > 0 ? got_addr[0] : -1, n_done);
        else n_pass++;
    endtask

    task automatic test_cfg_err_and_start_stop();
        start_run(5, 'h50000, 4, 1, 1'b0);
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || o_tvalid !== 1'b0)
            $display("FAIL err_step got err=%b busy=%b v=%b need 1 0 0", cfg_err, busy, o_tvalid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) $display("FAIL err_pulse got %b need 0", cfg_err);
        else n_pass++;
        start_run(8, 'h10000, 0, 1, 1'b0);
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || o_tvalid !== 1'b0)
            $display("FAIL err_flen got err=%b busy=%b v=%b need 1 0 0", cfg_err, busy, o_tvalid);
        else n_pass++;
        start_run(8, 'h10000, 3, 0, 1'b1);
        collect(12, 1'b0, -1);
        n_checks++;
        if (got_addr.size() != 3 || got_last[2] != 1 || n_done != 1 || busy !== 1'b0)
            $display("FAIL start_stop got n=%0d done=%0d busy=%b need n=3 done=1 busy=0",
                     got_addr.size(), n_done, busy);
        else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; start = 1'b0; stop = 1'b0; o_tready = 1'b1;
        cfg_table_len = '0; cfg_step = '0; cfg_frame_len = '0; cfg_num_frames = '0;
        test_reset();
        test_linear();
        test_fractional();
        test_backpressure();
        test_stop();
        test_clear();
        test_cfg_err_and_start_stop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
